// File: rtl/pmem_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pmem_responder_if
//  Description : Request/response bundle between a memory requester (core
//                load/store/fetch unit) and the pmem_responder array.
//                Valid/ready request channel plus valid/ready response
//                channel.
//  Revision    : 1.0  initial release
// ============================================================================
interface pmem_responder_if;
    // Request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    // Response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Requester side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Memory side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/pmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pmem_responder
//  Description : Single-outstanding memory responder backed by a word-
//                addressed on-chip array mapped at BASE_ADDR. A request is
//                accepted in IDLE, waits a programmable number of edges,
//                commits (read/write/fault) on the edge entering RESP and is
//                held there until the requester takes the response.
//  Revision    : 1.0  initial release
// ============================================================================
module pmem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic              clk,
    input  logic              reset,
    pmem_responder_if.slave   bus
);

    localparam int          c_depth    = 1 << ADDR_WIDTH;
    // 33-bit bounds so that a window touching the top of the 32-bit space
    // never wraps around.
    localparam logic [32:0] c_base     = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_limit    = c_base + (33'd4 << ADDR_WIDTH);
    // Counter value loaded at accept; the commit happens on the edge where
    // the counter is already 0, so RESP is entered LATENCY edges after accept.
    localparam logic [3:0]  c_cnt_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;

    logic                    r_we;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;

    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;

    logic [31:0]             r_mem [c_depth];

    logic                    w_accept;
    logic                    w_commit;
    logic                    w_err;
    logic [ADDR_WIDTH-1:0]   w_index;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // Fault: misaligned, below the window, or at/above its end.
    assign w_err    = (r_addr[1:0] != 2'b00)
                   || ({1'b0, r_addr} <  c_base)
                   || ({1'b0, r_addr} >= c_limit);

    assign w_index  = ADDR_WIDTH'((r_addr - BASE_ADDR) >> 2);

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Capture the request fields only at the accept edge.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_wstrb <= bus.req_wstrb;
        end
    end

    // Byte-masked array write on the commit edge; reset on that edge wins.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && r_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_index][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_cnt_init;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        // Read data is the word before this edge's write;
                        // only one request is ever in flight.
                        r_rsp_rdata <= (!w_err && !r_we) ? r_mem[w_index] : 32'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pmem_responder
//  Description : Bench for pmem_responder. Two instances share a clock: one
//                built with LATENCY=2, one with LATENCY=1. Directed and
//                random transactions are compared against a word-array
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pmem_responder;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE32 = 32'h8000_0000;
    localparam longint      BASE64 = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_responder_if ifa ();
    pmem_responder_if ifb ();

    pmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    pmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    // Index 0 drives dut_a, index 1 drives dut_b.
    logic [1:0]  rq_valid, rq_we, rs_ready;
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic [3:0]  rq_wstrb [2];
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata [2];

    assign ifa.req_valid = rq_valid[0];
    assign ifa.req_we    = rq_we[0];
    assign ifa.req_addr  = rq_addr[0];
    assign ifa.req_wdata = rq_wdata[0];
    assign ifa.req_wstrb = rq_wstrb[0];
    assign ifa.rsp_ready = rs_ready[0];
    assign req_ready[0]  = ifa.req_ready;
    assign rsp_valid[0]  = ifa.rsp_valid;
    assign rsp_err[0]    = ifa.rsp_err;
    assign rsp_rdata[0]  = ifa.rsp_rdata;

    assign ifb.req_valid = rq_valid[1];
    assign ifb.req_we    = rq_we[1];
    assign ifb.req_addr  = rq_addr[1];
    assign ifb.req_wdata = rq_wdata[1];
    assign ifb.req_wstrb = rq_wstrb[1];
    assign ifb.rsp_ready = rs_ready[1];
    assign req_ready[1]  = ifb.req_ready;
    assign rsp_valid[1]  = ifb.rsp_valid;
    assign rsp_err[1]    = ifb.rsp_err;
    assign rsp_rdata[1]  = ifb.rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one word array per instance plus "known" flags for
    // words whose full contents the bench has written.
    logic [31:0] mdl [2][DEPTH];
    bit          kn  [2][DEPTH];

    int pool [8] = '{0, 1, 2, 4, 5, 8, 100, 1023};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int s);
        return (s == 1) ? 1 : 2;
    endfunction

    function automatic void model(input int s, input bit we, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] st,
                                  output logic [31:0] e_rd, output bit e_er, output bit e_kn);
        longint ua;
        int     idx;
        ua   = {32'd0, a};
        e_er = (a % 4 != 0) || (ua < BASE64) || (ua >= BASE64 + 4 * DEPTH);
        e_rd = 32'd0;
        e_kn = 1'b1;
        if (!e_er) begin
            idx = int'((ua - BASE64) / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mdl[s][idx][8*b +: 8] = d[8*b +: 8];
                if (st == 4'hF) kn[s][idx] = 1'b1;
            end else begin
                e_rd = mdl[s][idx];
                e_kn = kn[s][idx];
            end
        end
    endfunction

    // One complete transaction: accept, latency, optional backpressure, handshake.
    task automatic txn(input int s, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                       output logic [31:0] rd, output logic er);
        logic [31:0] e_rd;
        bit          e_er, e_kn;
        int          n;
        logic [31:0] h_rd;
        logic        h_er;
        model(s, we, addr, wdata, wstrb, e_rd, e_er, e_kn);
        rq_we[s]    = we;
        rq_addr[s]  = addr;
        rq_wdata[s] = wdata;
        rq_wstrb[s] = wstrb;
        rq_valid[s] = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 50) begin @(posedge clk); #1; n++; end
        check("accept_ready", 32'(req_ready[s]), 32'd1);
        @(posedge clk); #1;
        // Scramble fields after accept; the responder must ignore them.
        rq_valid[s] = 1'b0;
        rq_we[s]    = ~we;
        rq_addr[s]  = $urandom;
        rq_wdata[s] = $urandom;
        rq_wstrb[s] = 4'hF;
        n = 0;
        while (!rsp_valid[s] && n < 40) begin
            check("busy_ready", 32'(req_ready[s]), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(lat(s)));
        check("rsp_valid", 32'(rsp_valid[s]), 32'd1);
        check("rsp_err", 32'(rsp_err[s]), 32'(e_er));
        if (e_kn) check("rsp_rdata", rsp_rdata[s], e_rd);
        rd   = rsp_rdata[s];
        er   = rsp_err[s];
        h_rd = rd;
        h_er = er;
        for (int i = 0; i < hold; i++) begin
            rq_valid[s] = 1'b1;
            rq_we[s]    = 1'b1;
            rq_addr[s]  = addr ^ 32'h4;
            rq_wdata[s] = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid[s]), 32'd1);
            check("hold_rdata", rsp_rdata[s], h_rd);
            check("hold_err", 32'(rsp_err[s]), 32'(h_er));
            check("hold_ready", 32'(req_ready[s]), 32'd0);
        end
        rq_valid[s] = 1'b0;
        rs_ready[s] = 1'b1;
        @(posedge clk); #1;
        rs_ready[s] = 1'b0;
        check("done_valid", 32'(rsp_valid[s]), 32'd0);
        check("done_ready", 32'(req_ready[s]), 32'd1);
        check("done_rdata", rsp_rdata[s], 32'd0);
        check("done_err", 32'(rsp_err[s]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          n;
        int          acc [$];

        reset    = 1'b1;
        rq_valid = 2'b00;
        rq_we    = 2'b00;
        rs_ready = 2'b00;
        for (int s = 0; s < 2; s++) begin
            rq_addr[s]  = 32'd0;
            rq_wdata[s] = 32'd0;
            rq_wstrb[s] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, first cycle after reset
        for (int s = 0; s < 2; s++) begin
            check("rst_valid", 32'(rsp_valid[s]), 32'd0);
            check("rst_ready", 32'(req_ready[s]), 32'd1);
            check("rst_rdata", rsp_rdata[s], 32'd0);
            check("rst_err", 32'(rsp_err[s]), 32'd0);
        end

        // Preload the pool of words used below (word 8 = 0x80000020 holds 0)
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 8; k++)
                txn(s, 1'b1, BASE32 + 32'(4 * pool[k]),
                    (pool[k] == 8) ? 32'd0 : $urandom, 4'hF, 0, r, e);

        // Full write then byte-strobe write, read back
        txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, r, e);
        check("wr_err", 32'(e), 32'd0);
        check("wr_rdata", r, 32'd0);
        txn(0, 1'b1, 32'h8000_0010, 32'h0000_AA00, 4'b0010, 0, r, e);
        txn(0, 1'b0, 32'h8000_0010, 32'd0, 4'd0, 0, r, e);
        check("strobe_rd", r, 32'hDEAD_AAEF);

        // Write with no strobes leaves the word alone
        txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, r, e);
        check("nostrb_err", 32'(e), 32'd0);

        // Faults
        txn(0, 1'b0, 32'h8000_0012, 32'd0, 4'd0, 0, r, e);
        check("mis_err", 32'(e), 32'd1);
        check("mis_rdata", r, 32'd0);
        txn(0, 1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 0, r, e);
        check("low_err", 32'(e), 32'd1);
        txn(0, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 0, r, e);
        check("high_err", 32'(e), 32'd1);
        txn(0, 1'b0, 32'h8000_0FFC, 32'd0, 4'd0, 0, r, e);
        check("top_err", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h8000_0010, 32'd0, 4'd0, 0, r, e);
        check("after_fault_rd", r, 32'hDEAD_AAEF);

        // Backpressure for 5 cycles
        txn(0, 1'b0, 32'h8000_0010, 32'd0, 4'd0, 5, r, e);
        check("bp_rd", r, 32'hDEAD_AAEF);

        // Reset while the write sits in WAIT
        rq_we[0]    = 1'b1;
        rq_addr[0]  = 32'h8000_0020;
        rq_wdata[0] = 32'h1111_1111;
        rq_wstrb[0] = 4'hF;
        rq_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rq_valid[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("wrst_valid", 32'(rsp_valid[0]), 32'd0);
        check("wrst_ready", 32'(req_ready[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("wrst_quiet", 32'(rsp_valid[0]), 32'd0);
        txn(0, 1'b0, 32'h8000_0020, 32'd0, 4'd0, 0, r, e);
        check("wrst_rd", r, 32'h0000_0000);

        // LATENCY=1 instance: single read, then a continuous stream
        txn(1, 1'b0, BASE32, 32'd0, 4'd0, 0, r, e);
        rs_ready[1] = 1'b1;
        rq_we[1]    = 1'b0;
        rq_addr[1]  = BASE32;
        rq_valid[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[1]) acc.push_back(cyc);
            if (rsp_valid[1]) check("stream_rdata", rsp_rdata[1], mdl[1][0]);
            @(posedge clk); #1;
        end
        rq_valid[1] = 1'b0;
        n = 0;
        while (!req_ready[1] && n < 10) begin @(posedge clk); #1; n++; end
        rs_ready[1] = 1'b0;
        check("stream_count", 32'(acc.size() >= 5), 32'd1);
        for (int i = 1; i < acc.size(); i++)
            check("stream_gap", 32'(acc[i] - acc[i-1]), 32'd3);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            int          s, kind, hold;
            bit          we;
            logic [31:0] a;
            s    = int'($urandom_range(1, 0));
            kind = int'($urandom_range(5, 0));
            we   = 1'($urandom);
            hold = int'($urandom_range(2, 0));
            a    = BASE32 + 32'(4 * pool[$urandom_range(7, 0)]);
            if (kind == 4) a = a + 32'($urandom_range(3, 1));
            if (kind == 5) begin
                case ($urandom_range(3, 0))
                    0: a = BASE32 - 32'd4;
                    1: a = BASE32 + 32'(4 * DEPTH);
                    2: a = 32'hFFFF_FFFC;
                    default: a = 32'h0000_0000;
                endcase
            end
            txn(s, we, a, $urandom, 4'($urandom), hold, r, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
